gcd_host: RTL and testbench

GCD_HOST -- requirements
Module: gcd_host

---
 rtl/gcd_host.sv | 148 ++++++++++++++
 tb/tb_gcd_host.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_host.sv
// GCD job host: queues operand pairs, sequences an external GCD core through
// LOAD/RUN, enforces a per-job cycle budget and holds each result until accepted.
module gcd_host #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [16:0] TIMEOUT    = 17'd70000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    output logic        in_ready,
    output logic [15:0] core_xi,
    output logic [15:0] core_yi,
    output logic        core_run,
    input  logic [15:0] core_xo,
    input  logic        core_rdy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic [15:0] out_gcd,
    output logic [16:0] out_cycles,
    output logic        out_err,
    output logic [1:0]  o_dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [31:0] r_mem [FIFO_DEPTH];
    logic [15:0] r_core_xi;
    logic [15:0] r_core_yi;
    logic [15:0] r_out_x;
    logic [15:0] r_out_y;
    logic [15:0] r_out_gcd;
    logic [16:0] r_out_cycles;
    logic        r_out_err;
    logic [16:0] r_cnt;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_head;

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both 1; valid is held with stable data until then.
    // in_ready derives only from the pointers, never from this cycle's pop.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign in_ready    = !w_full;
    assign core_xi     = r_core_xi;
    assign core_yi     = r_core_yi;
    assign core_run    = (r_state == S_RUN);
    assign out_valid   = (r_state == S_DONE);
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign out_gcd     = r_out_gcd;
    assign out_cycles  = r_out_cycles;
    assign out_err     = r_out_err;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_x, in_y};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_core_xi    <= '0;
            r_core_yi    <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_gcd    <= '0;
            r_out_cycles <= '0;
            r_out_err    <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_core_xi <= w_head[31:16];
                        r_core_yi <= w_head[15:0];
                        r_out_x   <= w_head[31:16];
                        r_out_y   <= w_head[15:0];
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= 17'd1;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // A result arriving on the timeout cycle still counts.
                    if (core_rdy) begin
                        r_out_gcd    <= core_xo;
                        r_out_cycles <= r_cnt;
                        r_out_err    <= 1'b0;
                        r_state      <= S_DONE;
                    end else if (r_cnt == TIMEOUT) begin
                        r_out_gcd    <= '0;
                        r_out_cycles <= TIMEOUT;
                        r_out_err    <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_host.sv
// Bench for gcd_host: subtractive GCD core model, directed and random jobs,
// expected results queued at push time and compared by an output monitor.
module tb_gcd_host;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_ready;
    logic [15:0] core_xi;
    logic [15:0] core_yi;
    logic        core_run;
    logic [15:0] core_xo;
    logic        core_rdy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [15:0] out_gcd;
    logic [16:0] out_cycles;
    logic        out_err;
    logic [1:0]  dbg_state;

    gcd_host #(.FIFO_DEPTH(4), .TIMEOUT(17'd8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ready(in_ready),
        .core_xi(core_xi), .core_yi(core_yi), .core_run(core_run),
        .core_xo(core_xo), .core_rdy(core_rdy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_gcd(out_gcd),
        .out_cycles(out_cycles), .out_err(out_err),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // subtractive GCD core: loads while run=0, one subtraction per run cycle,
    // registered ready; any zero operand yields 0
    logic [15:0] cx;
    logic [15:0] cy;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx <= '0; cy <= '0; core_rdy <= 1'b0; core_xo <= '0;
        end else if (!core_run) begin
            cx <= core_xi; cy <= core_yi; core_rdy <= 1'b0;
        end else if (cx == 0 || cy == 0) begin
            core_rdy <= 1'b1; core_xo <= '0;
        end else if (cx == cy) begin
            core_rdy <= 1'b1; core_xo <= cx;
        end else if (cx > cy) begin
            cx <= cx - cy;
        end else begin
            cy <= cy - cx;
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic [65:0] exp_q[$];

    function automatic logic [65:0] pk(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] g, input logic [16:0] c,
                                       input logic e);
        return {x, y, g, c, e};
    endfunction

    // reference: Euclid for the value, subtraction count for the core's time
    function automatic logic [65:0] ref_model(input logic [15:0] x, input logic [15:0] y);
        int a, b, t, steps, cyc;
        int g;
        if (x == 0 || y == 0) begin
            g = 0; steps = 0;
        end else begin
            a = x; b = y;
            while (b != 0) begin t = a % b; a = b; b = t; end
            g = a;
            a = x; b = y; steps = 0;
            while (a != b && steps <= TMO) begin
                if (a > b) a = a - b; else b = b - a;
                steps++;
            end
        end
        cyc = steps + 2;
        if (cyc > TMO) return pk(x, y, 16'd0, 17'(TMO), 1'b1);
        return pk(x, y, 16'(g), 17'(cyc), 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready), 1);
        chk({tag, "_core_run"},   32'(core_run), 0);
        chk({tag, "_core_xi"},    32'(core_xi), 0);
        chk({tag, "_core_yi"},    32'(core_yi), 0);
        chk({tag, "_out_valid"},  32'(out_valid), 0);
        chk({tag, "_out_x"},      32'(out_x), 0);
        chk({tag, "_out_y"},      32'(out_y), 0);
        chk({tag, "_out_gcd"},    32'(out_gcd), 0);
        chk({tag, "_out_cycles"}, 32'(out_cycles), 0);
        chk({tag, "_out_err"},    32'(out_err), 0);
    endtask

    // driver: one-cycle push attempt, expectation queued only if accepted
    task automatic push_try(input logic [15:0] x, input logic [15:0] y,
                            input logic [65:0] e, output bit acc);
        in_x = x; in_y = y; in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        if (acc) exp_q.push_back(e);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [15:0] x, input logic [15:0] y, input logic [65:0] e);
        bit acc;
        int n;
        acc = 0; n = 0;
        while (!acc && n < 500) begin
            push_try(x, y, e, acc);
            n++;
        end
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    // monitor / scoreboard
    int   cyc = 0;
    int   last_xfer = 0;
    int   last_gap = 0;
    bit   prev_valid = 0;
    bit   seen_valid = 0;
    logic [65:0] got;
    logic [65:0] want;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_valid = 0;
        end else begin
            if (out_valid && !prev_valid) begin
                last_gap = cyc - last_xfer;
                seen_valid = 1;
            end
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                last_xfer = cyc;
                got = {out_x, out_y, out_gcd, out_cycles, out_err};
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL result_unexpected: got x=%0d y=%0d gcd=%0d cyc=%0d err=%0d, none expected",
                             out_x, out_y, out_gcd, out_cycles, out_err);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL result: got x=%0d y=%0d gcd=%0d cyc=%0d err=%0d expected x=%0d y=%0d gcd=%0d cyc=%0d err=%0d",
                                 out_x, out_y, out_gcd, out_cycles, out_err,
                                 want[65:50], want[49:34], want[33:18], want[17:1], want[0]);
                    end
                end
            end
        end
    end

    bit pdone = 0;
    initial begin
        bit acc;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
        #1 rst = 1'b0;
        #2 chk_reset("por");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        step(); step();

        // basic jobs, zero operand, timeout then recovery
        push_wait(16'd12, 16'd18, pk(16'd12, 16'd18, 16'd6, 17'd4, 1'b0));
        wait_drain();
        push_wait(16'd0, 16'd5, pk(16'd0, 16'd5, 16'd0, 17'd2, 1'b0));
        wait_drain();
        push_wait(16'd65535, 16'd1, pk(16'd65535, 16'd1, 16'd0, 17'd8, 1'b1));
        push_wait(16'd7, 16'd7, pk(16'd7, 16'd7, 16'd7, 17'd2, 1'b0));
        wait_drain();

        // backpressure: one in flight, four queued, sixth push dropped
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_wait(16'(i + 2), 16'(2 * i + 4), ref_model(16'(i + 2), 16'(2 * i + 4)));
        end
        chk("full_in_ready", 32'(in_ready), 0);
        push_try(16'd3, 16'd6, ref_model(16'd3, 16'd6), acc);
        chk("full_drop", 32'(acc), 0);
        chk("held_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        wait_drain();

        // back-to-back jobs: 2 cycles of idle/load between them
        push_wait(16'd1, 16'd1, pk(16'd1, 16'd1, 16'd1, 17'd2, 1'b0));
        push_wait(16'd9, 16'd3, pk(16'd9, 16'd3, 16'd3, 17'd4, 1'b0));
        wait_drain();
        chk("b2b_gap", 32'(last_gap), 2 + 4 + 1);

        // reset mid-RUN with two pairs queued
        push_wait(16'd48, 16'd36, ref_model(16'd48, 16'd36));
        push_wait(16'd5, 16'd10, ref_model(16'd5, 16'd10));
        push_wait(16'd3, 16'd9, ref_model(16'd3, 16'd9));
        for (int n = 0; n < 50 && !core_run; n++) step();
        chk("run_before_rst", 32'(core_run), 1);
        #1 rst = 1'b0;
        exp_q.delete();
        #1 chk_reset("mid_run");
        step(); step();
        rst = 1'b1;
        seen_valid = 0;
        repeat (20) step();
        chk("no_stale_out", 32'(seen_valid), 0);
        push_wait(16'd8, 16'd12, pk(16'd8, 16'd12, 16'd4, 17'd4, 1'b0));
        wait_drain();

        // random jobs with random consumer stalls
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [15:0] rx, ry;
                    rx = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
                    ry = 16'($urandom_range(1, 24));
                    push_wait(rx, ry, ref_model(rx, ry));
                    repeat ($urandom_range(0, 3)) step();
                end
                pdone = 1;
            end
            begin
                for (int g = 0; g < 20000 && (!pdone || exp_q.size() != 0); g++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
